// File: rtl/monitor_reg_pkg.sv
// -----------------------------------------------------------------------------
// monitor_reg_pkg
// Shared constants for the monitor register bank: word address map, CTRL and
// STATUS bit positions, ID word layout and the byte-lane mask helper.
// -----------------------------------------------------------------------------
package monitor_reg_pkg;

  localparam logic [5:0] ADDR_ID       = 6'h00;
  localparam logic [5:0] ADDR_CTRL     = 6'h01;
  localparam logic [5:0] ADDR_STATUS   = 6'h02;
  localparam logic [5:0] ADDR_SNAP     = 6'h03;
  localparam logic [5:0] ADDR_FIFO     = 6'h04;
  localparam logic [5:0] ADDR_CHG      = 6'h05;
  localparam logic [5:0] ADDR_IN_BASE  = 6'h10;
  localparam logic [5:0] ADDR_OUT_BASE = 6'h20;

  localparam int CTRL_W           = 3;
  localparam int CTRL_SNAP_MODE   = 0;
  localparam int CTRL_IRQ_EN_FIFO = 1;
  localparam int CTRL_IRQ_EN_CHG  = 2;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_ANY_CHG   = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 8;

  localparam int ID_NIN_LSB   = 24;
  localparam int ID_NOUT_LSB  = 16;
  localparam int ID_DEPTH_LSB = 0;

  function automatic logic [31:0] id_word(input int n_in, input int n_out,
                                          input int depth);
    logic [31:0] w;
    w = '0;
    w[ID_NIN_LSB   +: 8]  = 8'(n_in);
    w[ID_NOUT_LSB  +: 8]  = 8'(n_out);
    w[ID_DEPTH_LSB +: 16] = 16'(depth);
    return w;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/monitor_byte_fifo.sv
// -----------------------------------------------------------------------------
// monitor_byte_fifo
// Synchronous byte FIFO with first-word-fall-through read data.
//   clk, rst      : clock, synchronous active-high reset (pointers/flags only)
//   push, din     : write strobe and byte; dropped when full unless popping
//   pop, dout     : read strobe; dout always shows the oldest entry
//   clr_ovf       : clears the sticky overflow flag (a same-cycle set wins)
//   empty, full   : occupancy flags
//   count         : entries held, 0..DEPTH
//   overflow      : sticky, set when a push is dropped
// -----------------------------------------------------------------------------
module monitor_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  input  logic          clr_ovf,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO that is
  // also being popped is accepted rather than counted as an overflow.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  assign dout = mem[rd_ptr];

  // ---- storage / pointer stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(do_push) - CW'(do_pop);
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/monitor_reg_bank.sv
// -----------------------------------------------------------------------------
// monitor_reg_bank
// Avalon-MM register bank for the monitor CPU: N_IN input channels (live or
// snapshot reads, per-channel change flags), N_OUT byte-lane writable output
// channels and a byte capture FIFO with a level interrupt.
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   avs_address/read/write      : word address and strobes (no waitrequest)
//   avs_writedata/byteenable    : write data and lane enables
//   avs_readdata/readdatavalid  : read response, fixed latency of one cycle
//   irq                         : registered level interrupt
//   i_reg_export                : input channels, channel k at [k*DATA_W +: DATA_W]
//   o_reg_export                : output channels, same packing
//   coe_done, coe_data          : byte stream into the FIFO, one byte per cycle
// -----------------------------------------------------------------------------
module monitor_reg_bank
  import monitor_reg_pkg::*;
#(
  parameter int N_IN       = 8,
  parameter int N_OUT      = 14,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [5:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic [3:0]              avs_byteenable,
  output logic [31:0]             avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    irq,
  input  logic [N_IN*DATA_W-1:0]  i_reg_export,
  output logic [N_OUT*DATA_W-1:0] o_reg_export,
  input  logic                    coe_done,
  input  logic [7:0]              coe_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] i_q_p0   [N_IN];
  logic [DATA_W-1:0] i_q_p1   [N_IN];
  logic [DATA_W-1:0] shadow_q [N_IN];
  logic [DATA_W-1:0] out_q    [N_OUT];
  logic [N_IN-1:0]   chg_q;
  logic [N_IN-1:0]   chg_set;
  logic [N_IN-1:0]   chg_clr;
  logic [CTRL_W-1:0] ctrl_q;

  logic        wr_en;
  logic        rd_en;
  logic        in_sel;
  logic        out_sel;
  logic [3:0]  idx;
  logic [31:0] wmask;
  logic [31:0] rd_data;
  logic        any_change;

  logic             fifo_pop;
  logic             fifo_clr_ovf;
  logic [7:0]       fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_ovf;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [31:0] wdata,
                                                   input logic [31:0] mask);
    return DATA_W'((32'(old_v) & ~mask) | (wdata & mask));
  endfunction

  // A simultaneous read and write is treated as a write only.
  assign wr_en   = avs_write;
  assign rd_en   = avs_read & ~avs_write;
  assign in_sel  = (avs_address[5:4] == ADDR_IN_BASE[5:4]);
  assign out_sel = (avs_address[5:4] == ADDR_OUT_BASE[5:4]);
  assign idx     = avs_address[3:0];
  assign wmask   = lane_mask(avs_byteenable);

  assign any_change   = |chg_q;
  assign fifo_pop     = rd_en && (avs_address == ADDR_FIFO);
  assign fifo_clr_ovf = wr_en && (avs_address == ADDR_STATUS) && avs_writedata[ST_OVERFLOW];
  assign chg_clr      = (wr_en && (avs_address == ADDR_CHG)) ? avs_writedata[N_IN-1:0] : '0;

  always_comb begin
    chg_set = '0;
    for (int i = 0; i < N_IN; i++) chg_set[i] = (i_q_p0[i] != i_q_p1[i]);
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out_pack
    assign o_reg_export[g*DATA_W +: DATA_W] = out_q[g];
  end

  monitor_byte_fifo #(.DEPTH(FIFO_DEPTH), .CW(CNT_W)) u_fifo (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .push     (coe_done),
    .din      (coe_data),
    .pop      (fifo_pop),
    .clr_ovf  (fifo_clr_ovf),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  // ---- input capture stage: p0 = registered pins, p1 = previous p0 ----
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < N_IN; i++) begin
        i_q_p0[i]   <= '0;
        i_q_p1[i]   <= '0;
        shadow_q[i] <= '0;
      end
      chg_q <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        i_q_p1[i] <= i_q_p0[i];
        i_q_p0[i] <= i_reg_export[i*DATA_W +: DATA_W];
        if (wr_en && (avs_address == ADDR_SNAP)) shadow_q[i] <= i_q_p0[i];
      end
      // New changes take priority over a same-cycle clear.
      chg_q <= (chg_q & ~chg_clr) | chg_set;
    end
  end

  // ---- register write stage ----
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl_q <= '0;
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
    end else if (wr_en) begin
      if (avs_address == ADDR_CTRL) ctrl_q <= avs_writedata[CTRL_W-1:0];
      for (int i = 0; i < N_OUT; i++) begin
        if (out_sel && (idx == 4'(i))) out_q[i] <= lane_merge(out_q[i], avs_writedata, wmask);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (avs_address)
      ADDR_ID:   rd_data = id_word(N_IN, N_OUT, FIFO_DEPTH);
      ADDR_CTRL: rd_data = 32'(ctrl_q);
      ADDR_STATUS: begin
        rd_data[ST_EMPTY]    = fifo_empty;
        rd_data[ST_FULL]     = fifo_full;
        rd_data[ST_OVERFLOW] = fifo_ovf;
        rd_data[ST_ANY_CHG]  = any_change;
        // At FIFO_DEPTH=256 a full count wraps to 0 here; full disambiguates.
        rd_data[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
      end
      ADDR_FIFO: rd_data = fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_dout};
      ADDR_CHG:  rd_data = 32'(chg_q);
      default:   rd_data = '0;
    endcase
    for (int i = 0; i < N_IN; i++) begin
      if (in_sel && (idx == 4'(i)))
        rd_data = 32'(ctrl_q[CTRL_SNAP_MODE] ? shadow_q[i] : i_q_p0[i]);
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (out_sel && (idx == 4'(i))) rd_data = 32'(out_q[i]);
    end
  end

  // ---- read response / interrupt stage ----
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
      irq               <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_en;
      if (rd_en) avs_readdata <= rd_data;
      irq <= (ctrl_q[CTRL_IRQ_EN_FIFO] & ~fifo_empty) |
             (ctrl_q[CTRL_IRQ_EN_CHG]  & any_change)  |
             fifo_ovf;
    end
  end

endmodule

// File: tb/tb_monitor_reg_bank.sv
module tb_monitor_reg_bank;

  localparam int N_IN       = 8;
  localparam int N_OUT      = 14;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 16;

  logic                    clk_clk;
  logic                    reset_reset;
  logic [5:0]              avs_address;
  logic                    avs_read;
  logic                    avs_write;
  logic [31:0]             avs_writedata;
  logic [3:0]              avs_byteenable;
  logic [31:0]             avs_readdata;
  logic                    avs_readdatavalid;
  logic                    irq;
  logic [N_IN*DATA_W-1:0]  i_reg_export;
  logic [N_OUT*DATA_W-1:0] o_reg_export;
  logic                    coe_done;
  logic [7:0]              coe_data;

  monitor_reg_bank #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq),
    .i_reg_export      (i_reg_export),
    .o_reg_export      (o_reg_export),
    .coe_done          (coe_done),
    .coe_data          (coe_data)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // A read accepted at a posedge (not during reset, not with a write) must be
  // answered at the very next posedge.
  always @(posedge clk_clk) rd_q <= avs_read & ~avs_write & ~reset_reset;

  // Scoreboard monitor.
  always @(negedge clk_clk) begin
    if (rd_q || avs_readdatavalid)
      check("readdatavalid_latency", 32'(avs_readdatavalid), 32'(rd_q));
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_readdatavalid: got readdata 0x%08h, required no response", avs_readdata);
      end else begin
        check(name_q.pop_front(), avs_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] a, input logic [31:0] e, input string n);
    avs_address = a; avs_read = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk_clk);
    avs_read = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    coe_data = b; coe_done = 1'b1;
    @(negedge clk_clk);
    coe_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset_reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0; i_reg_export = '0;
    coe_done = 1'b0; coe_data = '0;
    @(negedge clk_clk);
    idle(3);
    check("reset_readdata", avs_readdata, 32'h0);
    check("reset_readdatavalid", 32'(avs_readdatavalid), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_o_reg", 32'(|o_reg_export), 32'h0);
    reset_reset = 1'b0;
    idle(1);

    // ID and output channels
    bus_rd(6'h00, 32'h080E0010, "id_word");
    bus_wr(6'h20, 32'hAABBCCDD, 4'b0101);
    check("o_reg0_after_write", o_reg_export[31:0], 32'h00BB00DD);
    bus_rd(6'h20, 32'h00BB00DD, "out0_lane_write");
    bus_wr(6'h20, 32'h11223344, 4'b1010);
    bus_rd(6'h20, 32'h11BB33DD, "out0_lane_merge");
    bus_wr(6'h2D, 32'h11223344, 4'b1111);
    check("o_reg13_after_write", o_reg_export[13*32 +: 32], 32'h11223344);
    bus_rd(6'h2D, 32'h11223344, "out13_last");
    bus_wr(6'h2E, 32'hFFFFFFFF, 4'b1111);
    bus_rd(6'h2E, 32'h0, "out14_out_of_range");
    bus_rd(6'h30, 32'h0, "unmapped_0x30");
    bus_rd(6'h06, 32'h0, "unmapped_0x06");

    // Inputs, snapshot and change flags
    i_reg_export[2*32 +: 32] = 32'h1234;
    i_reg_export[7*32 +: 32] = 32'hCAFEBABE;
    idle(3);
    bus_rd(6'h17, 32'hCAFEBABE, "in7_live");
    bus_rd(6'h18, 32'h0, "in8_out_of_range");
    bus_rd(6'h05, 32'h84, "chg_initial");
    bus_wr(6'h05, 32'hFF, 4'b1111);
    bus_rd(6'h05, 32'h0, "chg_cleared");
    bus_wr(6'h01, 32'h1, 4'b1111);
    bus_wr(6'h03, 32'h0, 4'b1111);
    i_reg_export[2*32 +: 32] = 32'h5678;
    idle(3);
    bus_rd(6'h12, 32'h1234, "in2_snapshot");
    bus_wr(6'h01, 32'h0, 4'b1111);
    bus_rd(6'h12, 32'h5678, "in2_live");
    bus_rd(6'h05, 32'h4, "chg_bit2");
    bus_rd(6'h02, 32'h9, "status_any_change");
    bus_wr(6'h05, 32'h4, 4'b1111);
    bus_rd(6'h05, 32'h0, "chg_bit2_cleared");
    i_reg_export[31:0] = 32'h1;
    @(negedge clk_clk);
    bus_wr(6'h05, 32'h1, 4'b1111);
    bus_rd(6'h05, 32'h1, "chg_set_wins_over_clear");
    bus_wr(6'h05, 32'h1, 4'b1111);
    bus_rd(6'h05, 32'h0, "chg_bit0_cleared");

    // FIFO fill past capacity
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    bus_rd(6'h02, 32'h1006, "status_full_overflow");
    check("irq_on_overflow", 32'(irq), 32'h1);
    for (int i = 0; i < 16; i++) bus_rd(6'h04, 32'h100 | 32'(i), "fifo_pop_in_order");
    bus_rd(6'h04, 32'h0, "fifo_pop_when_empty");
    bus_rd(6'h02, 32'h5, "status_empty_overflow");
    bus_wr(6'h02, 32'h4, 4'b1111);
    bus_rd(6'h02, 32'h1, "status_overflow_cleared");
    idle(1);
    check("irq_after_ovf_clear", 32'(irq), 32'h0);

    // Push and pop together when full
    for (int i = 0; i < 16; i++) push_byte(8'(32'h20 + i));
    bus_rd(6'h02, 32'h1002, "status_full_no_ovf");
    coe_data = 8'h30; coe_done = 1'b1;
    bus_rd(6'h04, 32'h120, "pop_oldest_while_full_push");
    coe_done = 1'b0;
    bus_rd(6'h02, 32'h1002, "status_full_after_pushpop");
    for (int i = 1; i <= 16; i++) bus_rd(6'h04, 32'h100 | 32'(32'h20 + i), "fifo_drain");
    bus_rd(6'h02, 32'h1, "status_drained");

    // Push and pop together when empty
    coe_data = 8'h55; coe_done = 1'b1;
    bus_rd(6'h04, 32'h0, "pop_empty_with_push");
    coe_done = 1'b0;
    bus_rd(6'h02, 32'h100, "status_count_one");
    bus_rd(6'h04, 32'h155, "pop_pushed_byte");

    // FIFO interrupt timing
    bus_wr(6'h01, 32'h2, 4'b1111);
    push_byte(8'h66);
    check("irq_lag_one_cycle", 32'(irq), 32'h0);
    @(negedge clk_clk);
    check("irq_fifo_nonempty", 32'(irq), 32'h1);
    bus_rd(6'h04, 32'h166, "pop_irq_byte");
    check("irq_still_high_at_pop", 32'(irq), 32'h1);
    @(negedge clk_clk);
    check("irq_low_after_pop", 32'(irq), 32'h0);

    // Simultaneous read and write: write only
    avs_address = 6'h01; avs_writedata = 32'h6; avs_byteenable = 4'hF;
    avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0; avs_read = 1'b0;
    bus_rd(6'h01, 32'h6, "ctrl_after_write_read");

    // Reset in the middle of activity
    bus_wr(6'h21, 32'hDEADBEEF, 4'b1111);
    push_byte(8'h77);
    idle(1);
    check("irq_before_reset", 32'(irq), 32'h1);
    avs_address = 6'h00; avs_read = 1'b1; reset_reset = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    check("reset_read_no_valid", 32'(avs_readdatavalid), 32'h0);
    check("reset_irq_low", 32'(irq), 32'h0);
    check("reset_readdata_zero", avs_readdata, 32'h0);
    check("reset_o_reg_zero", 32'(|o_reg_export), 32'h0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    idle(3);
    bus_rd(6'h02, 32'h9, "status_after_reset");
    bus_rd(6'h01, 32'h0, "ctrl_after_reset");
    bus_rd(6'h21, 32'h0, "out1_after_reset");
    bus_rd(6'h04, 32'h0, "fifo_discarded_by_reset");

    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
        @(negedge clk_clk);
        guard++;
      end
      if (exp_q.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL read_drain: got %0d outstanding reads, required 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
